// File: rtl/apb_slave_pkg.sv
// apb_slave_pkg: shared constants, state type and helpers for the APB slave memory.
//   AW    - APB word-address width
//   DW    - data width of one storage word
//   CntW  - width of the wait-state down-counter
//   state_e        - transfer FSM states
//   addr_in_range  - true when a word address falls inside the populated storage
package apb_slave_pkg;

  // Kept in step with the values in the shared define file.
  localparam int unsigned AW   = 9;
  localparam int unsigned DW   = 8;
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } state_e;

  function automatic logic addr_in_range(input logic [AW-1:0] addr, input int unsigned depth);
    return (32'(addr) < depth);
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: DEPTH x DW storage for the APB slave memory.
// Ports:
//   pclk    - clock
//   presetn - synchronous active-high reset, clears every word
//   we      - write enable (ignored for out-of-range addresses)
//   waddr   - write word address
//   wdata   - write data
//   raddr   - read word address
//   rdata   - combinational read data, 0 for out-of-range addresses
import apb_slave_pkg::*;

module apb_slave_regfile #(
  parameter int unsigned DEPTH = 64
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];

  // Reset wins over a write landing in the same cycle.
  always_ff @(posedge pclk) begin
    if (presetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && addr_in_range(waddr, DEPTH)) begin
      mem_q[waddr[IdxW-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (addr_in_range(raddr, DEPTH)) begin
      rdata = mem_q[raddr[IdxW-1:0]];
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer backed by a small word memory, with a fixed number
// of wait states before pready.
// Parameters:
//   WAIT_CYCLES - wait cycles between the setup cycle and the ACCESS cycle (0..15)
//   DEPTH       - number of populated words; addresses >= DEPTH return pslverr
// Ports:
//   pclk    - clock
//   presetn - synchronous active-high reset
//   psel, penable, pwrite, paddr, pwdata - APB request
//   prdata  - read data, nonzero only in the ACCESS cycle of an in-range read
//   pready  - high for exactly the ACCESS cycle
//   pslverr - high in the ACCESS cycle of an out-of-range transfer
import apb_slave_pkg::*;

module apb_slave_mem #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DEPTH       = 64
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr
);

  localparam logic [CntW-1:0] WaitLoad =
      (WAIT_CYCLES == 0) ? '0 : CntW'(WAIT_CYCLES - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [AW-1:0]   addr_q;
  logic            write_q;
  logic [DW-1:0]   wdata_q;
  logic            pready_q;
  logic            pslverr_q;
  logic [DW-1:0]   prdata_q;

  logic [AW-1:0]   acc_addr;
  logic            acc_write;
  logic            acc_err;
  logic [DW-1:0]   acc_rdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_we;

  // Transfer that is about to enter ACCESS: on a zero-wait setup it comes straight
  // from the bus, otherwise from the copy captured during setup.
  assign acc_addr  = (state_q == IDLE) ? paddr : addr_q;
  assign acc_write = (state_q == IDLE) ? pwrite : write_q;
  assign acc_err   = !addr_in_range(acc_addr, DEPTH);
  assign acc_rdata = (acc_write || acc_err) ? '0 : mem_rdata;

  // Commit on the edge that ends ACCESS; pslverr_q is the error of this transfer.
  assign mem_we = (state_q == ACCESS) && write_q && !pslverr_q;

  apb_slave_regfile #(
    .DEPTH(DEPTH)
  ) u_regfile (
    .pclk   (pclk),
    .presetn(presetn),
    .we     (mem_we),
    .waddr  (addr_q),
    .wdata  (wdata_q),
    .raddr  (acc_addr),
    .rdata  (mem_rdata)
  );

  always_ff @(posedge pclk) begin
    if (presetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      // Outputs are only ever live for the single ACCESS cycle.
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      unique case (state_q)
        IDLE: begin
          // psel with penable already high has no setup cycle and is dropped.
          if (psel && !penable) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            if (WAIT_CYCLES == 0) begin
              state_q   <= ACCESS;
              pready_q  <= 1'b1;
              pslverr_q <= acc_err;
              prdata_q  <= acc_rdata;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WaitLoad;
            end
          end
        end
        WAIT: begin
          if (!(psel && penable)) begin
            // Requester withdrew mid-transfer: drop it without touching memory.
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q   <= ACCESS;
            pready_q  <= 1'b1;
            pslverr_q <= acc_err;
            prdata_q  <= acc_rdata;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        ACCESS: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: drives three apb_slave_mem instances (WAIT_CYCLES 0, 2, 3; DEPTH 64)
// with directed and random APB traffic and compares against a per-instance word array.
module tb_apb_slave_mem;

  localparam int NI    = 3;
  localparam int Depth = 64;

  logic                pclk = 1'b0;
  logic [NI-1:0]       presetn_v;
  logic [NI-1:0]       psel_v;
  logic [NI-1:0]       penable_v;
  logic [NI-1:0]       pwrite_v;
  logic [NI-1:0][8:0]  paddr_v;
  logic [NI-1:0][7:0]  pwdata_v;
  logic [NI-1:0][7:0]  prdata_v;
  logic [NI-1:0]       pready_v;
  logic [NI-1:0]       pslverr_v;

  logic [7:0] mdl [NI][Depth];

  int n_checks = 0;
  int n_errors = 0;

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    apb_slave_mem #(
      .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
      .DEPTH      (Depth)
    ) u_dut (
      .pclk   (pclk),
      .presetn(presetn_v[g]),
      .psel   (psel_v[g]),
      .penable(penable_v[g]),
      .pwrite (pwrite_v[g]),
      .paddr  (paddr_v[g]),
      .pwdata (pwdata_v[g]),
      .prdata (prdata_v[g]),
      .pready (pready_v[g]),
      .pslverr(pslverr_v[g])
    );
  end

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model(input int i);
    for (int a = 0; a < Depth; a++) mdl[i][a] = 8'h00;
  endtask

  task automatic chk_outputs_zero(input int i, input string tag);
    chk({tag, "_pready"}, pready_v[i], 0);
    chk({tag, "_pslverr"}, pslverr_v[i], 0);
    chk({tag, "_prdata"}, prdata_v[i], 0);
  endtask

  // All tasks start and end at posedge+1.
  task automatic do_reset(input int i);
    presetn_v[i] = 1'b1;
    @(posedge pclk); #1;
    chk_outputs_zero(i, "rst");
    clear_model(i);
    presetn_v[i] = 1'b0;
  endtask

  task automatic xfer(input int i, input logic wr, input logic [8:0] addr,
                      input logic [7:0] data, input logic scramble);
    int   cyc;
    logic exp_err;
    psel_v[i]    = 1'b1;
    penable_v[i] = 1'b0;
    pwrite_v[i]  = wr;
    paddr_v[i]   = addr;
    pwdata_v[i]  = data;
    @(posedge pclk); #1;
    penable_v[i] = 1'b1;
    if (scramble) begin
      pwrite_v[i] = 1'($urandom);
      paddr_v[i]  = 9'($urandom);
      pwdata_v[i] = 8'($urandom);
    end
    cyc = 0;
    @(negedge pclk);
    while (!pready_v[i] && cyc < 20) begin
      chk("wait_pslverr", pslverr_v[i], 0);
      chk("wait_prdata", prdata_v[i], 0);
      cyc++;
      @(negedge pclk);
    end
    chk("latency", cyc, wait_of(i));
    exp_err = (addr >= 9'(Depth));
    chk("pslverr", pslverr_v[i], exp_err);
    chk("prdata", prdata_v[i], (wr || exp_err) ? 8'h00 : mdl[i][addr[5:0]]);
    @(posedge pclk); #1;
    if (wr && !exp_err) mdl[i][addr[5:0]] = data;
    psel_v[i]    = 1'b0;
    penable_v[i] = 1'b0;
  endtask

  // Setup, then withdraw in the first WAIT cycle; only meaningful when WAIT_CYCLES > 0.
  task automatic xfer_abort(input int i, input logic [8:0] addr, input logic [7:0] data,
                            input logic drop_sel);
    psel_v[i]    = 1'b1;
    penable_v[i] = 1'b0;
    pwrite_v[i]  = 1'b1;
    paddr_v[i]   = addr;
    pwdata_v[i]  = data;
    @(posedge pclk); #1;
    if (drop_sel) begin
      psel_v[i]    = 1'b0;
      penable_v[i] = 1'b1;
    end else begin
      penable_v[i] = 1'b0;
      paddr_v[i]   = 9'h1ff;
    end
    if (!drop_sel) psel_v[i] = 1'b0;
    for (int k = 0; k < wait_of(i) + 3; k++) begin
      @(negedge pclk);
      chk("abort_pready", pready_v[i], 0);
    end
    @(posedge pclk); #1;
    psel_v[i]    = 1'b0;
    penable_v[i] = 1'b0;
  endtask

  // psel and penable high together from IDLE with no setup cycle.
  task automatic no_setup(input int i, input logic [8:0] addr, input logic [7:0] data);
    psel_v[i]    = 1'b1;
    penable_v[i] = 1'b1;
    pwrite_v[i]  = 1'b1;
    paddr_v[i]   = addr;
    pwdata_v[i]  = data;
    for (int k = 0; k < 5; k++) begin
      @(negedge pclk);
      chk("nosetup_pready", pready_v[i], 0);
    end
    @(posedge pclk); #1;
    psel_v[i]    = 1'b0;
    penable_v[i] = 1'b0;
  endtask

  // Write whose ACCESS cycle coincides with reset.
  task automatic xfer_reset_in_access(input int i, input logic [8:0] addr, input logic [7:0] data);
    int cyc;
    psel_v[i]    = 1'b1;
    penable_v[i] = 1'b0;
    pwrite_v[i]  = 1'b1;
    paddr_v[i]   = addr;
    pwdata_v[i]  = data;
    @(posedge pclk); #1;
    penable_v[i] = 1'b1;
    cyc = 0;
    @(negedge pclk);
    while (!pready_v[i] && cyc < 20) begin
      cyc++;
      @(negedge pclk);
    end
    chk("rstacc_latency", cyc, wait_of(i));
    presetn_v[i] = 1'b1;
    @(posedge pclk); #1;
    psel_v[i]    = 1'b0;
    penable_v[i] = 1'b0;
    chk_outputs_zero(i, "rstacc");
    @(posedge pclk); #1;
    chk_outputs_zero(i, "rstacc_hold");
    clear_model(i);
    presetn_v[i] = 1'b0;
  endtask

  initial begin
    presetn_v = '1;
    psel_v    = '0;
    penable_v = '0;
    pwrite_v  = '0;
    paddr_v   = '0;
    pwdata_v  = '0;
    @(posedge pclk); @(posedge pclk); #1;
    for (int i = 0; i < NI; i++) begin
      chk_outputs_zero(i, "init");
      clear_model(i);
    end
    presetn_v = '0;
    @(posedge pclk); #1;

    // Zero-wait write then back-to-back read.
    xfer(0, 1'b1, 9'h010, 8'hA5, 1'b0);
    xfer(0, 1'b0, 9'h010, 8'h00, 1'b0);
    // Three-wait read of a freshly reset word.
    xfer(2, 1'b0, 9'h000, 8'h00, 1'b0);
    // Out-of-range write must not alias onto word 0.
    xfer(0, 1'b1, 9'h040, 8'h3C, 1'b0);
    xfer(0, 1'b0, 9'h000, 8'h00, 1'b0);
    // Abort in first WAIT cycle.
    xfer_abort(1, 9'h005, 8'h55, 1'b1);
    xfer(1, 1'b0, 9'h005, 8'h00, 1'b0);
    // Reset during ACCESS.
    xfer(0, 1'b1, 9'h001, 8'h66, 1'b0);
    xfer_reset_in_access(0, 9'h001, 8'h77);
    xfer(0, 1'b0, 9'h001, 8'h00, 1'b0);
    // Back-to-back writes then reads.
    xfer(1, 1'b1, 9'h002, 8'h11, 1'b0);
    xfer(1, 1'b1, 9'h003, 8'h22, 1'b0);
    xfer(1, 1'b0, 9'h002, 8'h00, 1'b0);
    xfer(1, 1'b0, 9'h003, 8'h00, 1'b0);
    // Missing setup cycle is ignored.
    no_setup(1, 9'h004, 8'h99);
    xfer(1, 1'b0, 9'h004, 8'h00, 1'b0);

    // Random traffic with bus scrambling during WAIT/ACCESS.
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 80; n++) begin
        int unsigned op;
        logic [8:0]  a;
        op = $urandom_range(0, 11);
        a  = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
        if (op == 0) begin
          @(posedge pclk); #1;
        end else if (op == 1 && wait_of(i) > 0) begin
          xfer_abort(i, a, 8'($urandom), 1'($urandom));
        end else if (op == 2) begin
          no_setup(i, a, 8'($urandom));
        end else if (op == 3 && n % 20 == 3) begin
          xfer_reset_in_access(i, a, 8'($urandom));
        end else begin
          xfer(i, 1'($urandom), a, 8'($urandom), 1'($urandom));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock port pclk, reset port presetn (presetn=1 resets on the pclk rising edge).
REQ-002 Parameter: WAIT_CYCLES, default 1, number of wait cycles inserted before pready (0..15).
REQ-003 Parameter: DEPTH, default 64, number of DW-bit storage words (1..2^AW).
REQ-004 Port: pclk  in  1  clock.
REQ-005 Port: presetn  in  1  synchronous active-high reset.
REQ-006 Port: psel  in  1  completer select.
REQ-007 Port: penable  in  1  access phase.
REQ-008 Port: pwrite  in  1  1 = write, 0 = read.
REQ-009 Port: paddr  in  AW  word address.
REQ-010 Port: pwdata  in  DW  write data.
REQ-011 Port: prdata  out  DW  read data, valid only when pready=1 on a read.
REQ-012 Port: pready  out  1  transfer-complete indication.
REQ-013 Port: pslverr  out  1  transfer error, valid only when pready=1.

Function
REQ-014 SHALL implement states IDLE, WAIT and ACCESS; the setup phase is detected in IDLE.
REQ-015 In IDLE, psel=1 with penable=0 (setup cycle) SHALL capture paddr, pwrite and pwdata.
- Next state after the setup cycle: ACCESS if WAIT_CYCLES=0, else WAIT.
REQ-016 In IDLE, psel=1 with penable=1 (no setup cycle) SHALL be ignored; state stays IDLE and pready stays 0.
REQ-017 WAIT SHALL load a down-counter with WAIT_CYCLES-1 on entry and move to ACCESS when the counter reaches 0.
- pready=0 for exactly WAIT_CYCLES cycles after the setup cycle.
REQ-018 In ACCESS, pready=1 for exactly one cycle; the next state is always IDLE.
- A back-to-back setup cycle is therefore accepted in the cycle after ACCESS.
REQ-019 Write: at the edge ending ACCESS, store the captured pwdata at the captured address when pslverr=0.
REQ-020 Read: prdata SHALL equal mem[captured address] during ACCESS, and 0 in every other cycle.
- A read of an address written in the immediately preceding transfer SHALL return the new data.
REQ-021 An address >= DEPTH SHALL assert pslverr=1 in ACCESS.
- Write suppressed; prdata=0.
REQ-022 pslverr SHALL be 0 in every cycle other than ACCESS.
REQ-023 If psel or penable is 0 in any WAIT cycle (abort), the state SHALL return to IDLE.
- No write is performed; pready stays 0.
REQ-024 During WAIT and ACCESS, changes to paddr, pwrite or pwdata SHALL have no effect; the captured values are used.

Reset
REQ-025 presetn=1 SHALL set the state to IDLE, the counter to 0, pready=0, pslverr=0, prdata=0 and all DEPTH words to 0.
REQ-026 Reset asserted during WAIT or ACCESS SHALL abort the transfer with no memory update and take priority over every other event in that cycle.

Structure
REQ-027 Package apb_slave_pkg SHALL hold:
- AW=9 and DW=8, matching the values in the shared define file;
- the state enum {IDLE, WAIT, ACCESS};
- the wait-counter width constant (4).
REQ-028 Storage MAY be a single sub-module apb_slave_regfile (synchronous write, combinational read, synchronous reset clear); the FSM stays in apb_slave_mem.

Verification
REQ-029 WAIT_CYCLES=0, write 0xA5 to addr 0x010, then read 0x010 -> pready=1 in the cycle after setup for both transfers; read prdata=0xA5, pslverr=0.
REQ-030 WAIT_CYCLES=3, read addr 0x000 after reset -> pready low for 3 cycles after setup, then high for 1 cycle; prdata=0x00.
REQ-031 DEPTH=64, write 0x3C to addr 0x040 -> pslverr=1 with pready; a following read of 0x000 returns 0x00 (no aliasing).
REQ-032 WAIT_CYCLES=2, write 0x55 to 0x005 with psel dropped in the first WAIT cycle -> pready never asserts, state IDLE; a later read of 0x005 returns 0x00.
REQ-033 Write 0x77 to 0x001 with presetn=1 asserted in the ACCESS cycle -> no write; after reset, a read of 0x001 returns 0x00 and all outputs are 0 during reset.
REQ-034 Back-to-back writes 0x11 to 0x002 and 0x22 to 0x003, followed by reads of both -> the setup cycle directly after each ACCESS is accepted; reads return 0x11 and 0x22.
